// File: rtl/mmio_io_unit_pkg.sv
// Shared I/O-space offsets and helpers for the MEM-stage MMIO target.
package mmio_io_unit_pkg;

  localparam logic [7:0] IO_UART_CTRL = 8'h00;
  localparam logic [7:0] IO_UART_RX   = 8'h04;
  localparam logic [7:0] IO_UART_TX   = 8'h08;
  localparam logic [7:0] IO_CYCLE_CNT = 8'h10;
  localparam logic [7:0] IO_INST_CNT  = 8'h14;
  localparam logic [7:0] IO_CNT_RST   = 8'h18;

  function automatic logic [31:0] io_status(input logic rx_nonempty, input logic tx_empty);
    return {30'b0, rx_nonempty, tx_empty};
  endfunction

endpackage

// File: rtl/mmio_io_unit_if.sv
// MEM-stage access bus into the I/O target; rdata returns in WB.
interface mmio_io_unit_if;
  logic        io_en;
  logic        io_we;
  logic        stall;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output io_en, io_we, stall, addr, wdata, input rdata);
  modport slave  (input io_en, io_we, stall, addr, wdata, output rdata);
endinterface

// File: rtl/mmio_io_unit_sync_fifo.sv
// Single-clock FIFO with pointer-wrap-bit full/empty and a combinational head.
module mmio_io_unit_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;
  assign o_head    = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (w_push_ok) begin
      r_mem[r_wptr[AW-1:0]] <= i_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + (AW + 1)'(1);
      if (w_pop_ok)  r_rptr <= r_rptr + (AW + 1)'(1);
    end
  end

endmodule

// File: rtl/mmio_io_unit.sv
// MMIO target: UART RX FIFO, UART TX holding register, cycle/instret counters,
// and the registered load-data return path to WB.
module mmio_io_unit
  import mmio_io_unit_pkg::*;
#(
  parameter int unsigned RX_DEPTH = 8,
  parameter int unsigned CNT_W    = 32
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  mmio_io_unit_if.slave bus,
  input  logic         i_inst_retire,
  input  logic [7:0]   i_uart_rx_data,
  input  logic         i_uart_rx_valid,
  output logic         o_uart_rx_ready,
  output logic [7:0]   o_uart_tx_data,
  output logic         o_uart_tx_valid,
  input  logic         i_uart_tx_ready
);
  logic             w_acc;
  logic             w_rd;
  logic             w_wr;
  logic [7:0]       w_off;
  logic             w_rx_empty;
  logic             w_rx_full;
  logic [7:0]       w_rx_head;
  logic             w_pop;
  logic             w_tx_load;
  logic             w_cnt_clr;
  logic [31:0]      w_rd_data;
  logic             unused_bits;

  logic [31:0]      r_rdata;
  logic             r_tx_valid;
  logic [7:0]       r_tx_data;
  logic [CNT_W-1:0] r_cyc_cnt;
  logic [CNT_W-1:0] r_inst_cnt;

  assign w_acc       = bus.io_en && !bus.stall;
  assign w_rd        = w_acc && !bus.io_we;
  assign w_wr        = w_acc && bus.io_we;
  assign w_off       = bus.addr[7:0];
  assign unused_bits = ^{bus.addr[31:8], bus.wdata[31:8]};

  assign w_pop     = w_rd && (w_off == IO_UART_RX) && !w_rx_empty;
  // Uses pre-edge tx_valid, so a write racing the handshake is dropped.
  assign w_tx_load = w_wr && (w_off == IO_UART_TX) && !r_tx_valid;
  assign w_cnt_clr = w_wr && (w_off == IO_CNT_RST);

  mmio_io_unit_sync_fifo #(
    .WIDTH (8),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (i_uart_rx_valid),
    .i_data  (i_uart_rx_data),
    .i_pop   (w_pop),
    .o_head  (w_rx_head),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty)
  );

  always_comb begin
    w_rd_data = '0;
    case (w_off)
      IO_UART_CTRL: w_rd_data = io_status(!w_rx_empty, !r_tx_valid);
      IO_UART_RX:   w_rd_data = w_rx_empty ? 32'h0 : {24'b0, w_rx_head};
      IO_CYCLE_CNT: w_rd_data = 32'(r_cyc_cnt);
      IO_INST_CNT:  w_rd_data = 32'(r_inst_cnt);
      default:      w_rd_data = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rdata    <= '0;
      r_tx_valid <= 1'b0;
      r_tx_data  <= '0;
      r_cyc_cnt  <= '0;
      r_inst_cnt <= '0;
    end else begin
      r_rdata <= w_rd ? w_rd_data : 32'h0;

      if (w_tx_load) begin
        r_tx_valid <= 1'b1;
        r_tx_data  <= bus.wdata[7:0];
      end else if (r_tx_valid && i_uart_tx_ready) begin
        r_tx_valid <= 1'b0;
      end

      if (w_cnt_clr) begin
        r_cyc_cnt  <= '0;
        r_inst_cnt <= '0;
      end else begin
        r_cyc_cnt  <= r_cyc_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        r_inst_cnt <= r_inst_cnt + {{(CNT_W-1){1'b0}}, i_inst_retire};
      end
    end
  end

  assign bus.rdata       = r_rdata;
  assign o_uart_rx_ready = !w_rx_full;
  assign o_uart_tx_data  = r_tx_data;
  assign o_uart_tx_valid = r_tx_valid;

endmodule

// File: tb/tb_mmio_io_unit.sv
// Scoreboard bench for mmio_io_unit: every bus cycle pushes its expected rdata,
// popped and compared one edge later.
module tb_mmio_io_unit;
  import mmio_io_unit_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       inst_retire = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;

  logic [31:0] sb[$];
  int checks = 0;
  int errors = 0;

  mmio_io_unit_if bus ();

  mmio_io_unit #(
    .RX_DEPTH (8),
    .CNT_W    (32)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .bus             (bus),
    .i_inst_retire   (inst_retire),
    .i_uart_rx_data  (rx_data),
    .i_uart_rx_valid (rx_valid),
    .o_uart_rx_ready (rx_ready),
    .o_uart_tx_data  (tx_data),
    .o_uart_tx_valid (tx_valid),
    .i_uart_tx_ready (tx_ready)
  );

  always #5 clk = ~clk;

  task automatic bus_set(input logic en, input logic we, input logic stl, input logic [7:0] off,
                         input logic [31:0] wd, input logic [31:0] exp);
    bus.io_en = en;
    bus.io_we = we;
    bus.stall = stl;
    bus.addr  = {24'h800000, off};
    bus.wdata = wd;
    sb.push_back(exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] exp;
    bus.io_en = 1'b0; bus.io_we = 1'b0; bus.stall = 1'b0; bus.addr = '0; bus.wdata = '0;
    #12;
    checks++;
    if (bus.rdata !== 32'h0 || tx_valid !== 1'b0 || tx_data !== 8'h00 || rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: rdata=%h tx_valid=%b tx_data=%h rx_ready=%b, need 0/0/00/1",
               bus.rdata, tx_valid, tx_data, rx_ready);
    end
    rst_n = 1'b1;
    tick();
    bus_set(1, 0, 0, IO_UART_CTRL, 0, 32'h1);
    tick();
    exp = sb.pop_front(); checks++;
    if (bus.rdata !== exp) begin
      errors++; $display("FAIL reset_status: rdata=%h expected %h", bus.rdata, exp);
    end
  endtask

  task automatic test_rx();
    logic [31:0] exp;
    logic        rdy;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rx_ready !== 1'b1) begin
        errors++; $display("FAIL rx_ready_fill%0d: rx_ready=%b expected 1", i, rx_ready);
      end
      rx_valid = 1'b1;
      rx_data  = 8'h11 + 8'(i);
      bus_set(0, 0, 0, 8'h00, 0, 32'h0);
      tick();
      exp = sb.pop_front(); checks++;
      if (bus.rdata !== exp) begin
        errors++; $display("FAIL rx_fill_rdata%0d: rdata=%h expected %h", i, bus.rdata, exp);
      end
    end
    rx_data = 8'h19;
    bus_set(1, 0, 0, IO_UART_CTRL, 0, 32'h3);
    tick();
    exp = sb.pop_front(); checks++;
    if (bus.rdata !== exp || rx_ready !== 1'b0) begin
      errors++;
      $display("FAIL rx_full: rdata=%h rx_ready=%b expected %h/0", bus.rdata, rx_ready, exp);
    end
    for (int i = 0; i < 10; i++) begin
      rdy = rx_ready;
      bus_set(1, 0, 0, IO_UART_RX, 0, (i < 9) ? 32'h11 + 32'(i) : 32'h0);
      tick();
      if (rdy && rx_valid) rx_valid = 1'b0;
      exp = sb.pop_front(); checks++;
      if (bus.rdata !== exp) begin
        errors++; $display("FAIL rx_read%0d: rdata=%h expected %h", i, bus.rdata, exp);
      end
    end
    checks++;
    if (rx_valid !== 1'b0) begin
      errors++; $display("FAIL rx_ninth_taken: rx_valid still %b, expected 0", rx_valid);
    end
    rx_valid = 1'b0;
  endtask

  task automatic test_tx();
    logic [31:0] exp;
    tx_ready = 1'b0;
    bus_set(1, 1, 0, IO_UART_TX, 32'h1A5, 32'h0);
    tick();
    exp = sb.pop_front(); checks++;
    if (bus.rdata !== exp || tx_data !== 8'hA5 || tx_valid !== 1'b1) begin
      errors++;
      $display("FAIL tx_load: rdata=%h tx_data=%h tx_valid=%b expected %h/a5/1",
               bus.rdata, tx_data, tx_valid, exp);
    end
    bus_set(1, 0, 0, IO_UART_CTRL, 0, 32'h0);
    tick();
    exp = sb.pop_front(); checks++;
    if (bus.rdata !== exp) begin
      errors++; $display("FAIL tx_status_busy: rdata=%h expected %h", bus.rdata, exp);
    end
    bus_set(1, 1, 0, IO_UART_TX, 32'h42, 32'h0);
    tick();
    exp = sb.pop_front(); checks++;
    if (bus.rdata !== exp || tx_data !== 8'hA5) begin
      errors++;
      $display("FAIL tx_drop: rdata=%h tx_data=%h expected %h/a5", bus.rdata, tx_data, exp);
    end
    tx_ready = 1'b1;
    bus_set(0, 0, 0, 8'h00, 0, 32'h0);
    tick();
    tx_ready = 1'b0;
    exp = sb.pop_front(); checks++;
    if (bus.rdata !== exp || tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL tx_handshake: rdata=%h tx_valid=%b expected %h/0", bus.rdata, tx_valid, exp);
    end
    bus_set(1, 0, 0, IO_UART_CTRL, 0, 32'h1);
    tick();
    exp = sb.pop_front(); checks++;
    if (bus.rdata !== exp) begin
      errors++; $display("FAIL tx_status_empty: rdata=%h expected %h", bus.rdata, exp);
    end
    // Write racing the handshake must be dropped.
    bus_set(1, 1, 0, IO_UART_TX, 32'h77, 32'h0);
    tick();
    void'(sb.pop_front());
    tx_ready = 1'b1;
    bus_set(1, 1, 0, IO_UART_TX, 32'h33, 32'h0);
    tick();
    tx_ready = 1'b0;
    exp = sb.pop_front(); checks++;
    if (bus.rdata !== exp || tx_valid !== 1'b0 || tx_data !== 8'h77) begin
      errors++;
      $display("FAIL tx_race: rdata=%h tx_valid=%b tx_data=%h expected %h/0/77",
               bus.rdata, tx_valid, tx_data, exp);
    end
    bus_set(1, 0, 0, IO_UART_CTRL, 0, 32'h1);
    tick();
    exp = sb.pop_front(); checks++;
    if (bus.rdata !== exp) begin
      errors++; $display("FAIL tx_race_status: rdata=%h expected %h", bus.rdata, exp);
    end
  endtask

  task automatic test_counters();
    logic [31:0] exp;
    logic [31:0] rd_q[$];
    logic [7:0]  off_q[$];
    inst_retire = 1'b0;
    bus_set(1, 1, 0, IO_CNT_RST, 32'h1, 32'h0);
    tick();
    void'(sb.pop_front());
    for (int i = 0; i < 100; i++) begin
      inst_retire = (i < 60);
      bus_set(0, 0, 0, 8'h00, 0, 32'h0);
      tick();
      exp = sb.pop_front(); checks++;
      if (bus.rdata !== exp) begin
        errors++; $display("FAIL cnt_idle%0d: rdata=%h expected %h", i, bus.rdata, exp);
      end
    end
    inst_retire = 1'b0;
    off_q = '{IO_CYCLE_CNT, IO_INST_CNT, IO_CNT_RST, IO_INST_CNT, IO_CYCLE_CNT};
    rd_q  = '{32'd100, 32'd60, 32'd0, 32'd0, 32'd1};
    for (int i = 0; i < 5; i++) begin
      inst_retire = (i == 2);
      bus_set(1, (i == 2), 0, off_q[i], 32'h1, rd_q[i]);
      tick();
      exp = sb.pop_front(); checks++;
      if (bus.rdata !== exp) begin
        errors++; $display("FAIL cnt_read%0d: rdata=%h expected %h", i, bus.rdata, exp);
      end
    end
    inst_retire = 1'b0;
  endtask

  task automatic test_stall();
    logic [31:0] exp;
    for (int i = 0; i < 2; i++) begin
      rx_valid = 1'b1;
      rx_data  = (i == 0) ? 8'h5A : 8'h6B;
      bus_set(0, 0, 0, 8'h00, 0, 32'h0);
      tick();
      void'(sb.pop_front());
    end
    rx_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus_set(1, 0, (i < 3), IO_UART_RX, 0,
              (i == 3) ? 32'h5A : (i == 4) ? 32'h6B : 32'h0);
      tick();
      exp = sb.pop_front(); checks++;
      if (bus.rdata !== exp) begin
        errors++; $display("FAIL stall%0d: rdata=%h expected %h", i, bus.rdata, exp);
      end
    end
  endtask

  task automatic test_edge();
    logic [31:0] exp;
    rx_valid = 1'b1;
    rx_data  = 8'hC3;
    bus_set(1, 0, 0, IO_UART_RX, 0, 32'h0);
    tick();
    rx_valid = 1'b0;
    exp = sb.pop_front(); checks++;
    if (bus.rdata !== exp) begin
      errors++; $display("FAIL empty_push_pop: rdata=%h expected %h", bus.rdata, exp);
    end
    bus_set(1, 0, 0, IO_UART_RX, 0, 32'hC3);
    tick();
    exp = sb.pop_front(); checks++;
    if (bus.rdata !== exp) begin
      errors++; $display("FAIL pushed_byte: rdata=%h expected %h", bus.rdata, exp);
    end
    bus_set(1, 1, 0, 8'h0C, 32'hFF, 32'h0);
    tick();
    void'(sb.pop_front());
    bus_set(1, 0, 0, 8'h0C, 0, 32'h0);
    tick();
    exp = sb.pop_front(); checks++;
    if (bus.rdata !== exp) begin
      errors++; $display("FAIL unmapped_read: rdata=%h expected %h", bus.rdata, exp);
    end
    bus_set(0, 0, 0, 8'h00, 0, 32'h0);
    @(negedge clk);
    force dut.r_cyc_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_cyc_cnt;
    void'(sb.pop_front());
    for (int i = 0; i < 2; i++) begin
      bus_set(1, 0, 0, IO_CYCLE_CNT, 0, (i == 0) ? 32'hFFFF_FFFF : 32'h0);
      tick();
      exp = sb.pop_front(); checks++;
      if (bus.rdata !== exp) begin
        errors++; $display("FAIL cnt_wrap%0d: rdata=%h expected %h", i, bus.rdata, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] exp;
    logic [7:0]  off_q[$];
    logic [31:0] rd_q[$];
    inst_retire = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rx_valid = 1'b1;
      rx_data  = 8'h01 + 8'(i);
      bus_set((i == 0), 1, 0, IO_UART_TX, 32'h55, 32'h0);
      tick();
      void'(sb.pop_front());
    end
    rx_valid    = 1'b0;
    inst_retire = 1'b0;
    bus_set(1, 0, 0, IO_UART_RX, 0, 32'h01);
    tick();
    exp = sb.pop_front(); checks++;
    if (bus.rdata !== exp || tx_valid !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: rdata=%h tx_valid=%b expected %h/1", bus.rdata, tx_valid, exp);
    end
    bus.io_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.rdata !== 32'h0 || tx_valid !== 1'b0 || tx_data !== 8'h00 || rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: rdata=%h tx_valid=%b tx_data=%h rx_ready=%b, need 0/0/00/1",
               bus.rdata, tx_valid, tx_data, rx_ready);
    end
    #1;
    rst_n = 1'b1;
    off_q = '{IO_UART_RX, IO_UART_CTRL, IO_INST_CNT, IO_CYCLE_CNT};
    rd_q  = '{32'h0, 32'h1, 32'h0, 32'd3};
    for (int i = 0; i < 4; i++) begin
      bus_set(1, 0, 0, off_q[i], 0, rd_q[i]);
      tick();
      exp = sb.pop_front(); checks++;
      if (bus.rdata !== exp) begin
        errors++; $display("FAIL post_reset%0d: rdata=%h expected %h", i, bus.rdata, exp);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rx();
    test_tx();
    test_counters();
    test_stall();
    test_edge();
    test_reset_mid();
    bus_set(0, 0, 0, 8'h00, 0, 32'h0);
    void'(sb.pop_front());
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
